// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchronised rx, 5-9 data bits,
// optional parity, 1-2 stop bits, one-deep holding register.
// Ports: clk, rst_n (async low), rx (serial in, idle high),
//        data/valid/ready (holding register handshake),
//        parity_err, frame_err (per frame), overrun (sticky), busy.
module uart_rx_os #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);
   localparam logic PAR_ODD = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state;
   logic                 rx_s1;
   logic                 rx_s2;
   logic                 rx_prev;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_q;
   logic                 ferr_q;
   logic                 mid;
   logic                 done;
   logic                 ferr_fin;
   logic                 take;
   logic                 load;

   assign mid      = (cnt == FULL);
   assign done     = (state == S_STOP) && mid && (bcnt == LAST_S);
   // the last stop sample is folded in combinationally on the completion cycle
   assign ferr_fin = ferr_q | ~rx_s2;
   assign take     = valid & ready;
   assign load     = done & (~valid | ready);
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         bcnt   <= '0;
         shreg  <= '0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  cnt    <= '0;
                  bcnt   <= '0;
                  perr_q <= 1'b0;
                  ferr_q <= 1'b0;
                  state  <= S_START;
               end
            end
            S_START: begin
               if (cnt == HALF) begin
                  cnt <= '0;
                  // a high line at mid start bit is a glitch, not a frame
                  state <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (mid) begin
                  cnt   <= '0;
                  shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
                  if (bcnt == LAST_D) begin
                     bcnt  <= '0;
                     state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (mid) begin
                  cnt    <= '0;
                  perr_q <= ((^shreg) ^ rx_s2) != PAR_ODD;
                  state  <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (mid) begin
                  cnt <= '0;
                  if (!rx_s2)
                     ferr_q <= 1'b1;
                  if (bcnt == LAST_S) begin
                     bcnt  <= '0;
                     // leave at mid stop bit so an early next start is caught
                     state <= S_IDLE;
                  end else begin
                     bcnt <= bcnt + 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data       <= '0;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (load) begin
            data       <= shreg;
            parity_err <= (PARITY != 0) ? perr_q : 1'b0;
            frame_err  <= ferr_fin;
            valid      <= 1'b1;
         end else if (take) begin
            valid <= 1'b0;
         end
         if (done && !load)
            overrun <= 1'b1;
         else if (take)
            overrun <= 1'b0;
      end
   end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver, successor to the fixed 8-bit, one-clock-per-bit receiver. It runs from the system clock and counts a programmable number of clocks per bit. It synchronises and validates the start bit, then receives 5–9 data bits LSB-first, with optional parity and one or two stop bits. Each frame goes into a holding register with a valid/ready handshake and per-frame parity, framing and overrun flags. It sits between the RX pad and any byte consumer (command decoder, FIFO).

## Interface
- CLKS_PER_BIT, 16, system clocks per bit period; legal range ≥ 4.
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- rx  input  1  serial line; asynchronous; idle high.
- data  output  DATA_BITS  received frame data, LSB = first bit on the line; stable while valid = 1.
- valid  output  1  data and the per-frame flags hold an unread frame.
- ready  input  1  consumer accepts the frame in any cycle where valid && ready.
- parity_err  output  1  parity mismatch on the held frame; always 0 when PARITY = 0.
- frame_err  output  1  at least one stop bit sampled low on the held frame.
- overrun  output  1  sticky: a completed frame was dropped because the holding register was full.
- busy  output  1  receiver FSM not in IDLE.

## Operation
- rx passes through a 2-flop synchroniser, reset value 1. A third flop (rx_prev) provides falling-edge detection. All FSM decisions use the synchronised value.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- A clock counter of width clog2(CLKS_PER_BIT) runs in every state except IDLE. A bit counter of width clog2(DATA_BITS+1) counts data bits, then stop bits.
- IDLE: on a synchronised falling edge (prev = 1, cur = 0), clear both counters and go to START.
- START: when the clock counter reaches CLKS_PER_BIT/2 − 1 (mid start bit), sample rx.
  - rx = 1: false start; go to IDLE with nothing recorded.
  - rx = 0: clear the clock counter and go to DATA.
- DATA: each time the clock counter reaches CLKS_PER_BIT − 1 (mid-bit), shift rx into the shift register LSB-first and clear the clock counter.
  - After DATA_BITS samples, go to PARITY if PARITY ≠ 0, else to STOP.
- PARITY: sample at mid-bit. For even parity, the XOR of the data bits and the parity bit must be 0; for odd parity it must be 1. Store the mismatch.
- STOP: sample STOP_BITS times at mid-bit. Any low sample sets the frame error for this frame.
  - After the last stop sample (the completion cycle), go to IDLE at once, so a start edge arriving during the remaining half stop bit is still detected.
- Completion cycle:
  - If the holding register is empty, or valid && ready in that same cycle: load data, parity_err and frame_err, and set valid = 1.
  - Otherwise drop the new frame, keep the held frame intact, and set overrun.
- Handshake: valid && ready clears valid in the next cycle unless a new frame loads in the same cycle.
  - data, parity_err and frame_err change only on a load.
  - overrun clears on a handshake that does not itself coincide with a drop.
- A line held low (break) is received as a frame of all zeros with frame_err = 1. After a break, IDLE needs rx to return high before it detects another edge.

## Timing
- Reset values: valid = 0, data = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0, FSM in IDLE, counters at 0.
- Reset applied mid-frame aborts the frame immediately. No partial data is ever presented.
- Edge-to-START latency is 3 clocks after rx falls: 2 synchroniser clocks plus 1 detection clock.
- valid rises 1 clock after the completion cycle.
- Completion occurs (DATA_BITS + (PARITY ≠ 0) + STOP_BITS + 0.5) × CLKS_PER_BIT clocks after START is entered, ±1 clock.
- Tolerated baud mismatch between transmitter and receiver is ±(50/(bits per frame))% minus one clock of quantisation.
- Back-to-back frames with no idle gap are received without loss, provided the consumer asserts ready within one frame time.

## Test plan
- Parameters 8N1, CLKS_PER_BIT = 16: send 0xA5, ready held 1 -> valid pulses for 1 clock with data = 0xA5 and all flags 0; busy returns to 0.
- Glitch test: rx low for 4 clocks, then high -> FSM returns to IDLE; valid never rises.
- Parameters 7E1: send 0x55 with the parity bit forced wrong -> data = 0x55, parity_err = 1. Then send 0x55 with correct parity -> parity_err = 0.
- Parameters 8N2: send 0x3C with the second stop bit low -> data = 0x3C, frame_err = 1. Then send a break (rx low for 20 bit times) -> data = 0x00, frame_err = 1.
- ready held 0: send 0x11, then 0x22 -> data stays 0x11 and overrun = 1. Pulse ready -> valid = 0 and overrun = 0. Send 0x33 -> data = 0x33.
- Assert rst_n low mid-DATA while sending 0xFF -> all outputs go to reset values asynchronously. Release, send 0x81 -> data = 0x81.
